// File: rtl/matvec_mult_if.sv
// Start/clear handshake and result bus of the 8x8 matrix-vector multiplier.
interface matvec_mult_if #(
  parameter int N     = 8,
  parameter int ACC_W = 24
);
  logic             Clr;
  logic             start;
  logic             done;
  logic [ACC_W-1:0] results [0:N-1];

  modport master (output Clr, output start, input done, input results);
  modport slave  (input Clr, input start, output done, output results);
endinterface

// File: rtl/matvec_mult.sv
// 8x8 by 8x1 unsigned matrix-vector multiplier over a fixed operand store.
// state | meaning
// IDLE  | waiting for start
// FILL  | copying store words 0..8 into the A row buffers and the B buffer
// EXEC  | one column per cycle, all 8 lanes multiply-accumulate in parallel
// DONE  | results valid, done held until Clr or a new start
module matvec_mult #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input logic          clk,
  input logic          rst_n,
  matvec_mult_if.slave bus
);

  localparam int ROW_W = N * DATA_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EXEC, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ROW_W-1:0]   r_abuf [0:N-1];
  logic [ROW_W-1:0]   r_bbuf;
  logic [ACC_W-1:0]   r_acc  [0:N-1];
  logic               r_done;
  logic               w_start_ok, w_acc_clr, w_fill_en, w_exec_en, w_done_nxt;
  logic [ROW_W-1:0]   w_store_word;
  logic [2:0]         w_col;
  logic [2*DATA_W-1:0] w_prod [0:N-1];

  // Words 0..N-1 are A rows (A[i][j] = 8i+j+1), word N is B (B[j] = j+1).
  function automatic logic [ROW_W-1:0] store_rd(input logic [CNT_W-1:0] idx);
    logic [ROW_W-1:0] word;
    word = '0;
    for (int j = 0; j < N; j++) begin
      if (idx < CNT_W'(N))
        word[j*DATA_W +: DATA_W] = DATA_W'(N * int'(idx) + j + 1);
      else
        word[j*DATA_W +: DATA_W] = DATA_W'(j + 1);
    end
    return word;
  endfunction

  assign w_store_word = store_rd(r_cnt);
  assign w_col        = r_cnt[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.Clr) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            w_state_nxt = S_FILL;
            w_cnt_nxt   = '0;
          end
        end
        S_FILL: begin
          if (r_cnt == CNT_W'(N)) begin
            w_state_nxt = S_EXEC;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (r_cnt == CNT_W'(N - 1)) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // done is registered from the DONE state, so it rises one edge after EXEC ends.
  always_comb begin
    w_start_ok = bus.start && !bus.Clr && (r_state == S_IDLE || r_state == S_DONE);
    w_acc_clr  = bus.Clr || w_start_ok;
    w_fill_en  = !bus.Clr && (r_state == S_FILL);
    w_exec_en  = !bus.Clr && (r_state == S_EXEC);
    w_done_nxt = !bus.Clr && !bus.start && (r_state == S_DONE);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_prod[i] = (2*DATA_W)'(r_abuf[i][w_col*DATA_W +: DATA_W])
                * (2*DATA_W)'(r_bbuf[w_col*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_bbuf <= '0;
      for (int i = 0; i < N; i++) begin
        r_abuf[i] <= '0;
        r_acc[i]  <= '0;
      end
    end else begin
      r_done <= w_done_nxt;
      if (w_fill_en) begin
        if (r_cnt < CNT_W'(N))
          r_abuf[w_col] <= w_store_word;
        else
          r_bbuf <= w_store_word;
      end
      for (int i = 0; i < N; i++) begin
        if (w_acc_clr)
          r_acc[i] <= '0;
        else if (w_exec_en)
          r_acc[i] <= r_acc[i] + ACC_W'(w_prod[i]);
      end
    end
  end

  assign bus.done    = r_done;
  assign bus.results = r_acc;

endmodule

// File: tb/tb_matvec_mult.sv
// Randomized-timing scoreboard bench for matvec_mult against an arithmetic reference.
module tb_matvec_mult;
  localparam int N     = 8;
  localparam int ACC_W = 24;
  localparam int LAT   = 18;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  matvec_mult_if #(.N(N), .ACC_W(ACC_W)) bus ();

  matvec_mult #(.N(N), .DATA_W(8), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int                         rise;
    logic [N-1:0][ACC_W-1:0]    res;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_done = 1'b0;

  function automatic logic [ACC_W-1:0] ref_row(int i);
    int s;
    s = 0;
    for (int j = 0; j < N; j++) s += (8*i + j + 1) * (j + 1);
    return ACC_W'(s);
  endfunction

  function automatic exp_t make_exp(int rise);
    exp_t e;
    e.rise = rise;
    for (int i = 0; i < N; i++) e.res[i] = ref_row(i);
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising edge of done is matched against the oldest accepted start.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (bus.done && !prev_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("latency", cyc, e.rise);
          for (int i = 0; i < N; i++)
            check($sformatf("result[%0d]", i), int'(bus.results[i]), int'(e.res[i]));
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    sb_q.push_back(make_exp(cyc + 1 + LAT));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.Clr = 1'b1;
    @(negedge clk);
    bus.Clr = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int k;
    k = 0;
    while (!bus.done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", int'(bus.done), 1);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_done"}, int'(bus.done), 0);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_res[%0d]", tag, i), int'(bus.results[i]), 0);
  endtask

  task automatic check_nominal(string tag);
    check({tag, "_done"}, int'(bus.done), 1);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_res[%0d]", tag, i), int'(bus.results[i]), 288*i + 204);
  endtask

  task automatic expect_quiet(string tag, int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check(tag, int'(seen), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.Clr   = 1'b0;
    bus.start = 1'b0;
    rst_n     = 1'b0;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("idle");

    // nominal run, hold, restart
    pulse_clr();
    do_start();
    wait_done(1000);
    repeat (10 + $urandom_range(0, 5)) @(negedge clk);
    check_nominal("hold");
    do_start();
    check("restart_drop", int'(bus.done), 0);
    wait_done(1000);
    check_nominal("restart");

    // Clr while done, then Clr and start together from IDLE
    pulse_clr();
    check_zero("clr_done");
    @(negedge clk);
    bus.Clr   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.Clr   = 1'b0;
    bus.start = 1'b0;
    expect_quiet("clr_prio", 50);

    // start during FILL/EXEC is ignored
    do_start();
    k = $urandom_range(1, 15);
    repeat (k) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1000);
    check_nominal("busy_start");

    // asynchronous reset mid-operation
    do_start();
    repeat ($urandom_range(1, 15)) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_zero("reset_midop");
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    wait_done(1000);
    check_nominal("after_reset");

    // randomized mix of full runs, restarts from DONE and mid-run clears
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      case ($urandom_range(0, 2))
        0: begin
          do_start();
          wait_done(1000);
          check_nominal("rand_run");
        end
        1: begin
          do_start();
          repeat ($urandom_range(1, 15)) @(negedge clk);
          pulse_clr();
          sb_q.delete();
          check_zero("rand_clr");
          expect_quiet("rand_clr_quiet", 25);
        end
        default: begin
          do_start();
          wait_done(1000);
          repeat ($urandom_range(1, 8)) @(negedge clk);
          do_start();
          check("rand_restart_drop", int'(bus.done), 0);
          wait_done(1000);
          check_nominal("rand_restart");
        end
      endcase
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matvec_mult.md
Name: matvec_mult

Overview:
- Self-contained 8x8 by 8x1 unsigned matrix-vector multiplier.
- Matrix A and vector B live in an internal read-only store with fixed contents.
- On start, it loads the operands into row buffers, runs 8 parallel multiply-accumulate lanes, and presents 8 result words with a done flag.
- Used as the compute block in the minilab datapath, driven by a simple start/done handshake.

Parameters:
- N, 8, matrix dimension: rows, columns, vector length and number of MAC lanes; fixed at 8.
- DATA_W, 8, width of each A and B element (unsigned).
- ACC_W, 24, width of each accumulator and result word.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- Clr  input  1  synchronous clear of accumulators, done and FSM; priority over start.
- start  input  1  one-cycle-or-longer pulse that begins a computation when the FSM is in IDLE or DONE.
- done  output  1  high when results are valid; held until Clr, a new start, or reset.
- results  output  ACC_W x N (unpacked [0:7])  results[i] = sum over j=0..7 of A[i][j]*B[j].

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, all accumulators=0, all buffers=0, done=0, results all 24'h0.
- Internal store: 9 words of 64 bits, combinationally read.
  - Words 0..7 hold A rows 0..7, byte j = A[i][j], with byte 0 in bits [7:0].
  - Word 8 holds B.
  - Contents: A[i][j] = 8*i + j + 1; B[j] = j + 1.
- FSM states: IDLE, FILL, EXEC, DONE.
- IDLE:
  - On start=1 (and Clr=0), zero the accumulators and go to FILL; row counter=0.
- FILL: 9 cycles. Cycle k (k=0..8) captures store word k into row buffer k: buffers 0..7 are A, buffer 8 is B. After k=8, go to EXEC with column counter j=0.
- EXEC: 8 cycles. Cycle j: every lane i does acc[i] <= acc[i] + A[i][j]*B[j], in parallel. After j=7, go to DONE and set done=1.
- Latency: if start is sampled at rising edge T, done is first high after rising edge T+18 (9 FILL + 8 EXEC cycles, plus the IDLE->FILL edge).
- DONE:
  - done=1 and results held stable.
  - start=1 restarts: done<=0, accumulators zeroed, go to FILL.
- Clr=1 on any edge: accumulators<=0, done<=0, state<=IDLE. It overrides start in the same cycle.
- start while in FILL or EXEC is ignored.
- results[i] are driven directly from acc[i], so they may change during EXEC. They are only guaranteed valid while done=1.
- Arithmetic is unsigned: 8x8 gives a 16-bit product, zero-extended to 24 bits. The maximum sum, 8*255*255 = 520200, fits in 24 bits, so no overflow handling is needed.
- Asynchronous reset mid-FILL or mid-EXEC aborts immediately to the reset values. There is no partial result retention.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles -> done=0 and all results=0. Release rst_n, idle 5 cycles with no start -> outputs unchanged.
- Nominal run: release rst_n, pulse Clr one cycle, then pulse start one cycle.
  - done must rise exactly 18 edges after the start edge, well under a 1000-cycle timeout.
  - results[0..7] must be 0xCC, 0x1EC, 0x30C, 0x42C, 0x54C, 0x66C, 0x78C, 0x8AC, which is 288*i + 204.
- Hold and restart: after done, wait 10 cycles -> done stays 1 and results unchanged. Pulse start -> done drops next cycle and rises again 18 edges later with identical results (no accumulation carry-over).
- Clr priority: assert start and Clr in the same cycle from IDLE -> state stays IDLE, done never rises within 50 cycles. Assert Clr while done=1 -> done=0 and results all 0 on the next edge.
- Busy start ignored: pulse start again 5 cycles into a run -> done still rises at the original T+18 with the nominal results.
- Reset mid-operation: drop rst_n 10 cycles after start -> outputs zero immediately. Release rst_n and start -> nominal results after 18 edges.
